// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : RV32 instruction fetch with 1-cycle imem, prefetch FIFO, redirect
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [31:0]       i_imem_data,
    input  logic              i_redirect,
    input  logic [XLEN-1:0]   i_redirect_pc,
    output logic              o_valid,
    output logic [XLEN-1:0]   o_pc,
    output logic [31:0]       o_instr,
    input  logic              i_ready
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  pending_pc_q, pending_pc_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0]  pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic [XLEN-1:0]  w_req_pc;
    logic             w_room;
    logic             w_req;
    logic             w_push;
    logic             w_pop;
    logic             w_head_valid;
    logic             w_unused;

    assign w_unused = ^i_redirect_pc[1:0];

    always_comb begin
        w_req_pc     = i_redirect ? {i_redirect_pc[XLEN-1:2], 2'b00} : fetch_pc_q;
        // Credit counts in-flight work only; a same-cycle pop does not free a slot.
        w_room       = (count_q + CNT_W'(pending_q)) < CNT_W'(DEPTH);
        w_req        = !i_reset && (i_redirect || w_room);
        w_head_valid = (count_q != '0);
        w_push       = pending_q && !i_redirect && !i_reset;
        w_pop        = w_head_valid && i_ready && !i_redirect && !i_reset;
    end

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pending_pc_d = pending_pc_q;
        pending_d    = 1'b0;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (i_reset) begin
            fetch_pc_d   = RESET_PC;
            pending_pc_d = '0;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else if (i_redirect) begin
            fetch_pc_d   = w_req_pc + XLEN'(4);
            pending_pc_d = w_req_pc;
            pending_d    = 1'b1;
            count_d      = '0;
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
        end else begin
            pending_d = w_req;
            if (w_req) begin
                fetch_pc_d   = fetch_pc_q + XLEN'(4);
                pending_pc_d = fetch_pc_q;
            end
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            fetch_pc_q   <= RESET_PC;
            pending_pc_q <= '0;
            pending_q    <= 1'b0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pending_pc_q <= pending_pc_d;
            pending_q    <= pending_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            pc_mem_q[wr_ptr_q]    <= pending_pc_q;
            instr_mem_q[wr_ptr_q] <= i_imem_data;
        end
    end

    always_comb begin
        o_imem_req  = w_req;
        o_imem_addr = w_req_pc[ADDR_W+1:2];
        // Head is hidden during reset so decode never sees a doomed instruction.
        o_valid     = w_head_valid && !i_reset;
        o_pc        = o_valid ? pc_mem_q[rd_ptr_q]    : '0;
        o_instr     = o_valid ? instr_mem_q[rd_ptr_q] : C_NOP;
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed self-checking bench for fetch_stage
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          XLEN   = 32;
    localparam int          ADDR_W = 8;
    localparam logic [31:0] C_NOP  = 32'h0000_0013;

    logic              clk;
    logic              rst;
    logic              w_imem_req;
    logic [ADDR_W-1:0] w_imem_addr;
    logic [31:0]       r_imem_data;
    logic              r_redirect;
    logic [XLEN-1:0]   r_redirect_pc;
    logic              w_valid;
    logic [XLEN-1:0]   w_pc;
    logic [31:0]       w_instr;
    logic              r_ready;

    logic [31:0]       imem [256];
    int                n_checks;
    int                n_fail;
    int                n_req;

    fetch_stage #(
        .XLEN     (XLEN),
        .ADDR_W   (ADDR_W),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) u_dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .o_imem_req    (w_imem_req),
        .o_imem_addr   (w_imem_addr),
        .i_imem_data   (r_imem_data),
        .i_redirect    (r_redirect),
        .i_redirect_pc (r_redirect_pc),
        .o_valid       (w_valid),
        .o_pc          (w_pc),
        .o_instr       (w_instr),
        .i_ready       (r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1-cycle-latency instruction memory
    always @(posedge clk) begin
        if (w_imem_req) r_imem_data <= imem[w_imem_addr];
    end

    function automatic logic [31:0] exp_instr(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'hFF);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check_eq({tag, "_valid"}, {31'b0, w_valid}, 32'd1);
        check_eq({tag, "_pc"}, w_pc, pc);
        check_eq({tag, "_instr"}, w_instr, exp_instr(pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 256; k++) imem[k] = 32'h1000_0000 + k;
        r_imem_data   = '0;
        r_redirect    = 1'b0;
        r_redirect_pc = '0;
        r_ready       = 1'b1;
        rst           = 1'b1;

        // Reset state
        repeat (3) begin
            cyc(); #1;
            check_eq("rst_valid", {31'b0, w_valid}, 32'd0);
            check_eq("rst_req", {31'b0, w_imem_req}, 32'd0);
            check_eq("rst_pc", w_pc, 32'd0);
            check_eq("rst_instr", w_instr, C_NOP);
        end

        // Streaming fetch with decode always ready
        cyc(); rst = 1'b0; #1;
        check_eq("t1_req0", {31'b0, w_imem_req}, 32'd1);
        check_eq("t1_addr0", {24'b0, w_imem_addr}, 32'd0);
        check_eq("t1_valid0", {31'b0, w_valid}, 32'd0);
        cyc(); #1;
        check_eq("t1_valid1", {31'b0, w_valid}, 32'd0);
        check_eq("t1_addr1", {24'b0, w_imem_addr}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            cyc(); #1;
            check_head("t1_stream", 32'(k * 4));
        end

        // Decode stalled: exactly DEPTH requests, head held
        cyc(); rst = 1'b1; #1;
        cyc(); rst = 1'b0; r_ready = 1'b0; #1;
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (w_imem_req) n_req++;
            if (i >= 2) check_head("t2_hold", 32'h0);
            cyc(); #1;
        end
        check_eq("t2_nreq", n_req, 32'd4);
        check_eq("t2_req_full", {31'b0, w_imem_req}, 32'd0);
        r_ready = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            check_head("t2_drain", 32'(k * 4));
            cyc(); #1;
        end
        r_ready = 1'b0; #1;
        check_head("t2_drain4", 32'h10);

        // Refill to full, then redirect flushes everything
        repeat (6) cyc();
        #1;
        check_eq("t3_full_req", {31'b0, w_imem_req}, 32'd0);
        check_head("t3_full_head", 32'h10);
        r_redirect = 1'b1; r_redirect_pc = 32'h40; #1;
        check_eq("t3_redir_req", {31'b0, w_imem_req}, 32'd1);
        check_eq("t3_redir_addr", {24'b0, w_imem_addr}, 32'h10);
        cyc(); r_redirect = 1'b0; r_ready = 1'b1; #1;
        check_eq("t3_t1_valid", {31'b0, w_valid}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            check_head("t3_after", 32'h40 + 32'(k * 4));
        end

        // Back-to-back redirects: later target wins
        r_redirect = 1'b1; r_redirect_pc = 32'h40; #1;
        cyc(); r_redirect_pc = 32'h80; #1;
        check_eq("t4_t1_addr", {24'b0, w_imem_addr}, 32'h20);
        check_eq("t4_t1_valid", {31'b0, w_valid}, 32'd0);
        cyc(); r_redirect = 1'b0; #1;
        check_eq("t4_t2_valid", {31'b0, w_valid}, 32'd0);
        cyc(); #1;
        check_head("t4_t3", 32'h80);
        cyc(); #1;
        check_head("t4_t4", 32'h84);

        // Misaligned redirect target and word-address wrap
        r_redirect = 1'b1; r_redirect_pc = 32'h42; #1;
        check_eq("t5_mis_addr", {24'b0, w_imem_addr}, 32'h10);
        cyc(); r_redirect = 1'b0; #1;
        cyc(); #1;
        check_head("t5_mis", 32'h40);
        r_redirect = 1'b1; r_redirect_pc = 32'h3FC; #1;
        check_eq("t5_wrap_ff", {24'b0, w_imem_addr}, 32'hFF);
        cyc(); r_redirect = 1'b0; #1;
        check_eq("t5_wrap_req", {31'b0, w_imem_req}, 32'd1);
        check_eq("t5_wrap_00", {24'b0, w_imem_addr}, 32'h00);
        cyc(); #1;
        check_head("t5_pc3fc", 32'h3FC);
        cyc(); #1;
        check_head("t5_pc400", 32'h400);

        // Reset with FIFO full
        r_ready = 1'b0;
        repeat (8) cyc();
        #1;
        check_eq("t6_full_valid", {31'b0, w_valid}, 32'd1);
        check_eq("t6_full_req", {31'b0, w_imem_req}, 32'd0);
        rst = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("t6_rst_valid", {31'b0, w_valid}, 32'd0);
            check_eq("t6_rst_req", {31'b0, w_imem_req}, 32'd0);
            cyc();
        end
        rst = 1'b0; r_ready = 1'b1; #1;
        check_eq("t6_rel_req", {31'b0, w_imem_req}, 32'd1);
        check_eq("t6_rel_addr", {24'b0, w_imem_addr}, 32'd0);
        check_eq("t6_rel_valid0", {31'b0, w_valid}, 32'd0);
        cyc(); #1;
        check_eq("t6_rel_valid1", {31'b0, w_valid}, 32'd0);
        cyc(); #1;
        check_head("t6_first", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
